// File: rtl/binary_to_gray_if.sv
// Bus bundle for binary_to_gray: input word/valid, Gray output, adjacency flag.
// Decode-path signals exist only when BINARY_TO_GRAY_DECODE_EN is defined.
interface binary_to_gray_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] binary_in;
    logic             out_valid;
    logic [WIDTH-1:0] gray_out;
    logic             adj_out;
`ifdef BINARY_TO_GRAY_DECODE_EN
    logic             gray_valid;
    logic [WIDTH-1:0] gray_in;
    logic             bin_valid;
    logic [WIDTH-1:0] binary_out;

    modport master (
        output in_valid, binary_in, gray_valid, gray_in,
        input  out_valid, gray_out, adj_out, bin_valid, binary_out
    );
    modport slave (
        input  in_valid, binary_in, gray_valid, gray_in,
        output out_valid, gray_out, adj_out, bin_valid, binary_out
    );
`else
    modport master (
        output in_valid, binary_in,
        input  out_valid, gray_out, adj_out
    );
    modport slave (
        input  in_valid, binary_in,
        output out_valid, gray_out, adj_out
    );
`endif
endinterface

// File: rtl/binary_to_gray.sv
// Registered binary-to-Gray converter with Gray-adjacency flag, 1-cycle latency.
// Optional registered Gray-to-binary path when BINARY_TO_GRAY_DECODE_EN is defined.
module binary_to_gray #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    binary_to_gray_if.slave     b2g_io
);

    logic [WIDTH-1:0] gray_d, gray_q;
    logic [WIDTH-1:0] diff;
    logic             adj_d, adj_q;
    logic             out_valid_q;
    logic             prev_valid_q;

    // gray_q only changes on accept, so it doubles as the previous accepted code.
    always_comb begin
        gray_d = b2g_io.binary_in ^ (b2g_io.binary_in >> 1);
        diff   = gray_d ^ gray_q;
        adj_d  = prev_valid_q && ($countones(diff) == 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q       <= '0;
            adj_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            prev_valid_q <= 1'b0;
        end else begin
            out_valid_q <= b2g_io.in_valid;
            if (b2g_io.in_valid) begin
                gray_q       <= gray_d;
                adj_q        <= adj_d;
                prev_valid_q <= 1'b1;
            end
        end
    end

    assign b2g_io.gray_out  = gray_q;
    assign b2g_io.adj_out   = adj_q;
    assign b2g_io.out_valid = out_valid_q;

`ifdef BINARY_TO_GRAY_DECODE_EN
    logic [WIDTH-1:0] bin_d, bin_q;
    logic             bin_valid_q;

    // b[i] is the XOR of all Gray bits at or above i.
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            bin_d[i] = ^(b2g_io.gray_in >> i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q       <= '0;
            bin_valid_q <= 1'b0;
        end else begin
            bin_valid_q <= b2g_io.gray_valid;
            if (b2g_io.gray_valid) begin
                bin_q <= bin_d;
            end
        end
    end

    assign b2g_io.binary_out = bin_q;
    assign b2g_io.bin_valid  = bin_valid_q;
`endif

endmodule

// File: tb/tb_binary_to_gray.sv
// Table-driven bench for binary_to_gray (WIDTH 4 and 1), plus reset and decode sequences.
module tb_binary_to_gray;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    binary_to_gray_if #(.WIDTH(4)) bus4 ();
    binary_to_gray_if #(.WIDTH(1)) bus1 ();

    binary_to_gray #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .b2g_io (bus4)
    );

    binary_to_gray #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .b2g_io (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [3:0] bin;
        logic [3:0] gray;
        logic       adj;
        logic       ov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic vld, input logic [3:0] bin, input logic [3:0] gray,
                       input logic adj, input logic ov);
        vec_t v;
        v.vld = vld; v.bin = bin; v.gray = gray; v.adj = adj; v.ov = ov;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    logic [3:0] gray_seq [16];

    initial begin
        n_cmp = 0;
        n_err = 0;
        gray_seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

        // Basic conversion and adjacency
        add(1, 4'b0000, 4'b0000, 0, 1);
        add(1, 4'b0001, 4'b0001, 1, 1);
        add(1, 4'b0010, 4'b0011, 1, 1);
        add(1, 4'b0100, 4'b0110, 0, 1);
        add(1, 4'b1111, 4'b1000, 0, 1);
        // Hold
        add(1, 4'b0101, 4'b0111, 0, 1);
        add(0, 4'b1010, 4'b0111, 0, 0);
        add(0, 4'b0011, 4'b0111, 0, 0);
        add(0, 4'b1111, 4'b0111, 0, 0);
        // Count 0..15 then wrap to 0; 0111 -> 0000 is three bits apart
        for (int i = 0; i < 16; i++) begin
            add(1, 4'(i), gray_seq[i], (i != 0), 1);
        end
        add(1, 4'b0000, 4'b0000, 1, 1);
        // Repeat of the same code is distance 0
        add(1, 4'b0000, 4'b0000, 0, 1);
        // Invalid gap does not break adjacency tracking
        add(0, 4'b0000, 4'b0000, 0, 0);
        add(1, 4'b0001, 4'b0001, 1, 1);

        bus4.in_valid  = 1'b0;
        bus4.binary_in = '0;
        bus1.in_valid  = 1'b0;
        bus1.binary_in = '0;
`ifdef BINARY_TO_GRAY_DECODE_EN
        bus4.gray_valid = 1'b0;
        bus4.gray_in    = '0;
        bus1.gray_valid = 1'b0;
        bus1.gray_in    = '0;
`endif
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gray", 0, 32'(bus4.gray_out), 0);
        check("rst_ov", 0, 32'(bus4.out_valid), 0);
        check("rst_adj", 0, 32'(bus4.adj_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            bus4.in_valid  = vecs[i].vld;
            bus4.binary_in = vecs[i].bin;
            @(posedge clk);
            @(negedge clk);
            check("gray", i, 32'(bus4.gray_out), 32'(vecs[i].gray));
            check("ov", i, 32'(bus4.out_valid), 32'(vecs[i].ov));
            check("adj", i, 32'(bus4.adj_out), 32'(vecs[i].adj));
        end

        // Asynchronous reset mid-stream
        bus4.in_valid  = 1'b1;
        bus4.binary_in = 4'b0010;
        @(posedge clk);
        #2;
        check("pre_rst_gray", 0, 32'(bus4.gray_out), 32'h3);
        rst_n = 1'b0;
        #1;
        check("async_gray", 0, 32'(bus4.gray_out), 0);
        check("async_ov", 0, 32'(bus4.out_valid), 0);
        check("async_adj", 0, 32'(bus4.adj_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus4.binary_in = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_gray", 0, 32'(bus4.gray_out), 32'h2);
        check("post_rst_ov", 0, 32'(bus4.out_valid), 1);
        check("post_rst_adj", 0, 32'(bus4.adj_out), 0);
        bus4.binary_in = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_gray", 1, 32'(bus4.gray_out), 32'h3);
        check("post_rst_adj", 1, 32'(bus4.adj_out), 1);
        bus4.in_valid = 1'b0;

        // WIDTH = 1 passes the bit through; 1 -> 0 -> 1 are all adjacent
        bus1.in_valid  = 1'b1;
        bus1.binary_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("w1_gray", 0, 32'(bus1.gray_out), 1);
        check("w1_adj", 0, 32'(bus1.adj_out), 0);
        bus1.binary_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w1_gray", 1, 32'(bus1.gray_out), 0);
        check("w1_adj", 1, 32'(bus1.adj_out), 1);
        check("w1_ov", 1, 32'(bus1.out_valid), 1);
        bus1.in_valid = 1'b0;

`ifdef BINARY_TO_GRAY_DECODE_EN
        bus4.gray_valid = 1'b1;
        bus4.gray_in    = 4'b1000;
        @(posedge clk);
        @(negedge clk);
        check("dec_bin", 0, 32'(bus4.binary_out), 32'hF);
        check("dec_vld", 0, 32'(bus4.bin_valid), 1);
        bus4.gray_in    = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        check("dec_bin", 1, 32'(bus4.binary_out), 32'h4);
        check("dec_vld", 1, 32'(bus4.bin_valid), 1);
        bus4.gray_valid = 1'b0;
        bus4.gray_in    = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        check("dec_hold", 2, 32'(bus4.binary_out), 32'h4);
        check("dec_vld", 2, 32'(bus4.bin_valid), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
